// File: rtl/keypad_entry_unit_if.sv
// Memory-side request/response bundle between data memory and the keypad entry unit.
// Data memory drives the request; the entry unit returns the converted value.
interface keypad_entry_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  read_complete;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output read_enable,
    input  read_complete,
    input  read_data
  );

  modport slave (
    input  read_enable,
    output read_complete,
    output read_data
  );
endinterface

// File: rtl/keypad_entry_unit.sv
// Debounced 4x4 keypad decimal entry with BCD-to-binary conversion, pause toggle
// and a multiplexed, leading-blanked display scanner.
module keypad_entry_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DIGITS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned SCAN_DIV        = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            key_coord,
  keypad_entry_unit_if.slave    mem,
  output logic                  cpu_pause,
  output logic                  cpu_resume,
  output logic                  entry_active,
  output logic [MAX_DIGITS-1:0] seg_enable,
  output logic [3:0]            seg_digit
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BCD_W = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CONVERT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIGIT,
    K_BACK,
    K_ENTER,
    K_PAUSE
  } key_kind_e;

  // ---------------- key decode ----------------
  key_kind_e  key_kind;
  logic [3:0] key_value;

  always_comb begin
    key_kind  = K_NONE;
    key_value = '0;
    case (key_coord)
      8'h7D: begin key_kind = K_DIGIT; key_value = 4'd0; end
      8'hEE: begin key_kind = K_DIGIT; key_value = 4'd1; end
      8'hED: begin key_kind = K_DIGIT; key_value = 4'd2; end
      8'hEB: begin key_kind = K_DIGIT; key_value = 4'd3; end
      8'hDE: begin key_kind = K_DIGIT; key_value = 4'd4; end
      8'hDD: begin key_kind = K_DIGIT; key_value = 4'd5; end
      8'hDB: begin key_kind = K_DIGIT; key_value = 4'd6; end
      8'hBE: begin key_kind = K_DIGIT; key_value = 4'd7; end
      8'hBD: begin key_kind = K_DIGIT; key_value = 4'd8; end
      8'hBB: begin key_kind = K_DIGIT; key_value = 4'd9; end
      8'h7E: key_kind = K_BACK;
      8'h7B: key_kind = K_ENTER;
      8'hE7: key_kind = K_PAUSE;
      default: ;
    endcase
  end

  // ---------------- debounce ----------------
  logic [7:0]      last_key;
  logic [DB_W-1:0] stable_cnt;
  logic [DB_W-1:0] stable_next;
  logic            armed;
  logic            press;

  // stable_next counts the current cycle too; it saturates so long holds never wrap.
  always_comb begin
    if (key_coord != last_key)
      stable_next = DB_W'(1);
    else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES))
      stable_next = stable_cnt;
    else
      stable_next = stable_cnt + 1'b1;
  end

  assign press = armed && (key_coord != 8'hFF) && (stable_next == DB_W'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_key   <= 8'hFF;
      stable_cnt <= '0;
      armed      <= 1'b1;
    end else begin
      last_key   <= key_coord;
      stable_cnt <= stable_next;
      if (press)
        armed <= 1'b0;
      else if ((key_coord == 8'hFF) && (stable_next == DB_W'(DEBOUNCE_CYCLES)))
        armed <= 1'b1;
    end
  end

  // ---------------- entry / conversion FSM ----------------
  state_e                state_q, state_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rcomp_q, rcomp_d;
  logic                  paused_q, paused_d;
  logic                  pause_d, resume_d;
  logic [3:0]            digit_at [MAX_DIGITS];

  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_digit_view
    assign digit_at[g] = bcd_q[4*g +: 4];
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    rcomp_d  = 1'b0;
    paused_d = paused_q;
    pause_d  = 1'b0;
    resume_d = 1'b0;

    if (press && (key_kind == K_PAUSE)) begin
      paused_d = !paused_q;
      pause_d  = !paused_q;
      resume_d = paused_q;
    end

    case (state_q)
      S_IDLE: begin
        if (mem.read_enable) begin
          state_d = S_ENTRY;
          bcd_d   = '0;
          count_d = '0;
        end
      end
      S_ENTRY: begin
        if (!mem.read_enable) begin
          state_d = S_IDLE;
        end else if (press) begin
          case (key_kind)
            K_DIGIT: begin
              if (count_q < CNT_W'(MAX_DIGITS)) begin
                bcd_d   = (bcd_q << 4) | BCD_W'(key_value);
                count_d = count_q + 1'b1;
              end
            end
            K_BACK: begin
              if (count_q != '0) begin
                bcd_d   = bcd_q >> 4;
                count_d = count_q - 1'b1;
              end
            end
            K_ENTER: begin
              state_d = S_CONVERT;
              acc_d   = '0;
              idx_d   = IDX_W'(MAX_DIGITS - 1);
            end
            default: ;
          endcase
        end
      end
      S_CONVERT: begin
        // acc*10 as (acc<<3)+(acc<<1): wraps modulo 2^DATA_WIDTH naturally.
        acc_d = (acc_q << 3) + (acc_q << 1) + DATA_WIDTH'(digit_at[idx_q]);
        if (idx_q == '0) begin
          rdata_d = acc_d;
          rcomp_d = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!mem.read_enable)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- display scanner ----------------
  logic [DIV_W-1:0]      scan_div;
  logic [IDX_W-1:0]      scan_pos;
  logic [MAX_DIGITS-1:0] seg_en_d;
  logic [3:0]            seg_dig_d;

  always_comb begin
    seg_en_d  = '1;
    seg_dig_d = '0;
    if ((CNT_W'(scan_pos) < count_q) || (scan_pos == '0)) begin
      seg_en_d  = ~(MAX_DIGITS'(1) << scan_pos);
      seg_dig_d = digit_at[scan_pos];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      rdata_q    <= '0;
      rcomp_q    <= 1'b0;
      paused_q   <= 1'b0;
      cpu_pause  <= 1'b0;
      cpu_resume <= 1'b0;
      scan_div   <= '0;
      scan_pos   <= '0;
      seg_enable <= '1;
      seg_digit  <= '0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
      rcomp_q    <= rcomp_d;
      paused_q   <= paused_d;
      cpu_pause  <= pause_d;
      cpu_resume <= resume_d;
      seg_enable <= seg_en_d;
      seg_digit  <= seg_dig_d;
      if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        scan_pos <= (scan_pos == IDX_W'(MAX_DIGITS - 1)) ? '0 : scan_pos + 1'b1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end
    end
  end

  assign mem.read_data     = rdata_q;
  assign mem.read_complete = rcomp_q;
  assign entry_active      = (state_q == S_ENTRY) || (state_q == S_CONVERT);

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Bench for keypad_entry_unit: 32-bit and 16-bit instances share one stimulus and one
// behavioural model; directed keypad sequences with literal result checks.
module tb_keypad_entry_unit;
  localparam int unsigned MAXD = 8;
  localparam int unsigned DB   = 4;
  localparam int unsigned SD   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key   = 8'hFF;
  logic       re    = 1'b0;

  always #5 clk = ~clk;

  keypad_entry_unit_if #(.DATA_WIDTH(32)) bus32 ();
  keypad_entry_unit_if #(.DATA_WIDTH(16)) bus16 ();
  assign bus32.read_enable = re;
  assign bus16.read_enable = re;

  logic            p32, r32, ea32, p16, r16, ea16;
  logic [MAXD-1:0] se32, se16;
  logic [3:0]      sd32, sd16;

  keypad_entry_unit #(.DATA_WIDTH(32), .MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut32 (
    .clk(clk), .rst_n(rst_n), .key_coord(key), .mem(bus32),
    .cpu_pause(p32), .cpu_resume(r32), .entry_active(ea32),
    .seg_enable(se32), .seg_digit(sd32)
  );

  keypad_entry_unit #(.DATA_WIDTH(16), .MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut16 (
    .clk(clk), .rst_n(rst_n), .key_coord(key), .mem(bus16),
    .cpu_pause(p16), .cpu_resume(r16), .entry_active(ea16),
    .seg_enable(se16), .seg_digit(sd16)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CONV = 2, M_DONE = 3;
  int          m_digs[$];          // entered digits, most significant first
  int          m_mode;
  int          m_left;
  longint      m_v32, m_v16, m_rd32, m_rd16;
  bit          m_rc, m_pause, m_resume, m_paused, m_armed, m_ready = 0;
  logic [7:0]  m_last;
  int          m_run, m_div, m_pos;
  logic [MAXD-1:0] m_en;
  int          m_dig;

  function automatic int digit_of(input logic [7:0] c);
    case (c)
      8'h7D: return 0;  8'hEE: return 1;  8'hED: return 2;  8'hEB: return 3;
      8'hDE: return 4;  8'hDD: return 5;  8'hDB: return 6;  8'hBE: return 7;
      8'hBD: return 8;  8'hBB: return 9;  default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    bit     ev;
    longint v;
    if (!rst_n) begin
      m_ready = 1; m_digs.delete(); m_mode = M_IDLE; m_left = 0;
      m_rd32 = 0; m_rd16 = 0; m_rc = 0; m_pause = 0; m_resume = 0; m_paused = 0;
      m_armed = 1; m_last = 8'hFF; m_run = 0; m_div = 0; m_pos = 0;
      m_en = '1; m_dig = 0;
    end else begin
      // display reflects the position and digits held before this edge
      m_en = '1; m_dig = 0;
      if (m_pos < ((m_digs.size() > 0) ? m_digs.size() : 1)) begin
        m_en[m_pos] = 1'b0;
        m_dig = (m_pos < m_digs.size()) ? m_digs[m_digs.size() - 1 - m_pos] : 0;
      end
      m_div++;
      if (m_div == SD) begin m_div = 0; m_pos = (m_pos + 1) % MAXD; end

      if (key == m_last) m_run++;
      else begin m_last = key; m_run = 1; end
      ev = m_armed && (key != 8'hFF) && (m_run == DB);
      if (ev) m_armed = 0;
      if (key == 8'hFF && m_run >= DB) m_armed = 1;

      m_rc = 0; m_pause = 0; m_resume = 0;
      if (ev && key == 8'hE7) begin
        if (m_paused) m_resume = 1; else m_pause = 1;
        m_paused = !m_paused;
      end

      case (m_mode)
        M_IDLE: if (re) begin m_mode = M_ENTRY; m_digs.delete(); end
        M_ENTRY: begin
          if (!re) m_mode = M_IDLE;
          else if (ev) begin
            if (digit_of(key) >= 0) begin
              if (m_digs.size() < MAXD) m_digs.push_back(digit_of(key));
            end else if (key == 8'h7E) begin
              if (m_digs.size() > 0) void'(m_digs.pop_back());
            end else if (key == 8'h7B) begin
              v = 0;
              foreach (m_digs[i]) v = v * 10 + m_digs[i];
              m_v32 = v % (64'd1 << 32);
              m_v16 = v % (64'd1 << 16);
              m_left = MAXD;
              m_mode = M_CONV;
            end
          end
        end
        M_CONV: begin
          m_left--;
          if (m_left == 0) begin
            m_rd32 = m_v32; m_rd16 = m_v16; m_rc = 1; m_mode = M_DONE;
          end
        end
        default: if (!re) m_mode = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      chk("read_complete32", bus32.read_complete, m_rc);
      chk("read_complete16", bus16.read_complete, m_rc);
      chk("read_data32", bus32.read_data, m_rd32);
      chk("read_data16", bus16.read_data, m_rd16);
      chk("cpu_pause", p32, m_pause);
      chk("cpu_resume", r32, m_resume);
      chk("cpu_pause16", p16, m_pause);
      chk("entry_active", ea32, (m_mode == M_ENTRY || m_mode == M_CONV));
      chk("entry_active16", ea16, (m_mode == M_ENTRY || m_mode == M_CONV));
      chk("seg_enable", se32, m_en);
      chk("seg_enable16", se16, m_en);
      if (m_en != '1) chk("seg_digit", sd32, m_dig);
    end
  end

  // ---------------- stimulus ----------------
  int np, nr;

  task automatic step();
    @(posedge clk); #1;
    if (p32) np++;
    if (r32) nr++;
  endtask

  task automatic press(input logic [7:0] code, input int hold = 6);
    step();
    key = code;
    repeat (hold) step();
    key = 8'hFF;
    repeat (6) step();
  endtask

  task automatic enter_check(input longint e32, input longint e16);
    int seen;
    seen = 0;
    step();
    key = 8'h7B;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 6) key = 8'hFF;
      if (bus32.read_complete === 1'b1 && seen == 0) begin
        seen = k;
        chk("enter_to_complete_latency", k, DB + 8);
        chk("result32", bus32.read_data, e32);
        chk("result16", bus16.read_data, e16);
      end
    end
    if (seen == 0) chk("read_complete_timeout", 0, 1);
  endtask

  task automatic end_txn();
    re = 1'b0;
    repeat (3) step();
    chk("entry_active_after", ea32, 1'b0);
  endtask

  task automatic start_txn();
    re = 1'b1;
    step();
  endtask

  initial begin
    int cfe, cfd, cfb, cff, bad, rcs;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_read_complete", bus32.read_complete, 1'b0);
    chk("rst_read_data", bus32.read_data, 32'd0);
    chk("rst_seg_enable", se32, 8'hFF);
    chk("rst_seg_digit", sd32, 4'd0);
    chk("rst_entry_active", ea32, 1'b0);
    chk("rst_pause_resume", {p32, r32}, 2'b00);
    rst_n = 1'b1;
    repeat (6) step();

    start_txn(); press(8'hEE); press(8'hED); press(8'hEB); enter_check(123, 123); end_txn();
    start_txn(); press(8'hDE); press(8'hDD); press(8'h7E); press(8'hDB); enter_check(46, 46); end_txn();
    start_txn(); press(8'h7E); enter_check(0, 0); end_txn();
    start_txn(); repeat (9) press(8'hBB); enter_check(99999999, 57599); end_txn();
    start_txn(); press(8'hBE); repeat (4) press(8'h7D); enter_check(70000, 4464); end_txn();

    // bounce never fires; a long hold fires exactly once
    start_txn();
    for (int i = 0; i < 10; i++) begin
      key = 8'hEE; step(); step();
      key = 8'hFF; step(); step();
    end
    repeat (6) step();
    press(8'hEE, 20);
    enter_check(1, 1);
    end_txn();

    np = 0; nr = 0;
    press(8'hE7);
    chk("pause_pulses", np, 1);
    chk("resume_pulses_none", nr, 0);
    np = 0; nr = 0;
    press(8'hE7);
    chk("pause_pulses_none", np, 0);
    chk("resume_pulses", nr, 1);
    start_txn(); press(8'hDE); press(8'hE7); press(8'hE7); press(8'hED);
    enter_check(42, 42); end_txn();

    // display of 305 after abort keeps the buffer
    start_txn(); press(8'hEB); press(8'h7D); press(8'hDD);
    re = 1'b0;
    repeat (4) step();
    chk("abort_no_entry", ea32, 1'b0);
    cfe = 0; cfd = 0; cfb = 0; cff = 0; bad = 0;
    repeat (16) begin
      step();
      case (se32)
        8'hFE: begin cfe++; if (sd32 != 4'd5) bad++; end
        8'hFD: begin cfd++; if (sd32 != 4'd0) bad++; end
        8'hFB: begin cfb++; if (sd32 != 4'd3) bad++; end
        8'hFF: cff++;
        default: bad++;
      endcase
    end
    chk("disp_pos0_cycles", cfe, 2);
    chk("disp_pos1_cycles", cfd, 2);
    chk("disp_pos2_cycles", cfb, 2);
    chk("disp_blank_cycles", cff, 10);
    chk("disp_bad_digit", bad, 0);

    // reset in the middle of conversion
    start_txn(); press(8'hBE);
    step();
    key = 8'h7B;
    repeat (DB + 3) step();
    chk("mid_convert_active", ea32, 1'b1);
    rst_n = 1'b0;
    step();
    chk("rst2_read_complete", bus32.read_complete, 1'b0);
    chk("rst2_read_data", bus32.read_data, 32'd0);
    chk("rst2_seg_enable", se32, 8'hFF);
    chk("rst2_seg_digit", sd32, 4'd0);
    chk("rst2_entry_active", ea32, 1'b0);
    rst_n = 1'b1;
    key = 8'hFF;
    rcs = 0;
    repeat (15) begin
      step();
      if (bus32.read_complete === 1'b1) rcs++;
    end
    chk("no_complete_after_reset", rcs, 0);
    end_txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
